// File: rtl/car_pkg.sv
// Shared definitions for the car broadcaster: default geometry, orientation
// encodings, FSM states and the coordinate shown for empty slots.
package car_pkg;

  localparam int NUM_CARS = 12;
  localparam int STEP     = 2;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Coordinate value presented for a slot that holds no car
  localparam logic [9:0] INACTIVE_COORD = 10'd1023;

  typedef enum logic [1:0] {
    ORIENT_POS_X = 2'd0,
    ORIENT_POS_Y = 2'd1,
    ORIENT_NEG_X = 2'd2,
    ORIENT_NEG_Y = 2'd3
  } orientT;

  typedef enum logic {
    BCAST  = 1'b0,
    UPDATE = 1'b1
  } fsmStateT;

endpackage

// File: rtl/car_step.sv
// Combinational next-position calculation for one car, moving STEP pixels
// along its orientation and wrapping around the screen edges.
module car_step #(
  parameter int STEP     = car_pkg::STEP,
  parameter int SCREEN_W = car_pkg::SCREEN_W,
  parameter int SCREEN_H = car_pkg::SCREEN_H
) (
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [1:0] orient,
  output logic [9:0] xNext,
  output logic [9:0] yNext
);
  import car_pkg::*;

  localparam logic [10:0] STEP11 = 11'(STEP);
  localparam logic [10:0] W11    = 11'(SCREEN_W);
  localparam logic [10:0] H11    = 11'(SCREEN_H);

  logic [10:0] xWide;
  logic [10:0] yWide;
  logic [10:0] xPlus;
  logic [10:0] yPlus;

  assign xWide = {1'b0, x};
  assign yWide = {1'b0, y};
  assign xPlus = xWide + STEP11;
  assign yPlus = yWide + STEP11;

  // Move along the selected axis; the untouched axis passes straight through
  always_comb begin
    xNext = x;
    yNext = y;
    case (orientT'(orient))
      ORIENT_POS_X: xNext = (xPlus >= W11) ? 10'(xPlus - W11) : 10'(xPlus);
      ORIENT_POS_Y: yNext = (yPlus >= H11) ? 10'(yPlus - H11) : 10'(yPlus);
      ORIENT_NEG_X: xNext = (xWide < STEP11) ? 10'(xWide + W11 - STEP11) : 10'(xWide - STEP11);
      ORIENT_NEG_Y: yNext = (yWide < STEP11) ? 10'(yWide + H11 - STEP11) : 10'(yWide - STEP11);
      default: begin
        xNext = x;
        yNext = y;
      end
    endcase
  end

endmodule

// File: rtl/car_broadcaster.sv
// Car slot table that continuously broadcasts one slot per cycle and, on a
// tick, runs a single movement pass over every slot.
// Optional feature: define CAR_BROADCASTER_OVERRUN_EN to add the sticky
// tick_overrun output that flags ticks dropped during a movement pass.
module car_broadcaster #(
  parameter int NUM_CARS = car_pkg::NUM_CARS,
  parameter int STEP     = car_pkg::STEP,
  parameter int SCREEN_W = car_pkg::SCREEN_W,
  parameter int SCREEN_H = car_pkg::SCREEN_H
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       spawn_valid,
  output logic       spawn_ready,
  input  logic [9:0] spawn_x,
  input  logic [9:0] spawn_y,
  input  logic [1:0] spawn_orient,
  output logic [9:0] carX,
  output logic [9:0] carY,
  output logic [1:0] carOrient,
  output logic [3:0] carIndex,
  output logic       carValid
`ifdef CAR_BROADCASTER_OVERRUN_EN
  ,
  output logic       tick_overrun
`endif
);
  import car_pkg::*;

  localparam logic [3:0] LAST_IDX = 4'(NUM_CARS - 1);

  logic [9:0]          slotX      [NUM_CARS];
  logic [9:0]          slotY      [NUM_CARS];
  logic [1:0]          slotOrient [NUM_CARS];
  logic [NUM_CARS-1:0] slotActive;

  fsmStateT   state;
  fsmStateT   stateNext;
  logic [3:0] idxNext;

  logic       anyFree;
  logic [3:0] freeIdx;
  logic       spawnAccept;
  logic       spawnHit;

  logic [9:0] baseX;
  logic [9:0] baseY;
  logic [1:0] baseOrient;
  logic       baseActive;
  logic [9:0] stepX;
  logic [9:0] stepY;
  logic       moveEn;

  assign spawn_ready = !rst && (state == BCAST) && anyFree;
  assign spawnAccept = spawn_valid && spawn_ready;

  // Find the lowest-numbered empty slot for the next spawn
  always_comb begin
    anyFree = 1'b0;
    freeIdx = '0;
    for (int i = NUM_CARS - 1; i >= 0; i--) begin
      if (!slotActive[i]) begin
        anyFree = 1'b1;
        freeIdx = 4'(i);
      end
    end
  end

  // Sequence the slot index: free-running in BCAST, one full sweep in UPDATE
  always_comb begin
    stateNext = state;
    idxNext   = carIndex;
    case (state)
      BCAST: begin
        if (tick) begin
          stateNext = UPDATE;
          idxNext   = '0;
        end else begin
          idxNext = (carIndex == LAST_IDX) ? 4'd0 : carIndex + 4'd1;
        end
      end
      UPDATE: begin
        if (carIndex == LAST_IDX) begin
          stateNext = BCAST;
          idxNext   = '0;
        end else begin
          idxNext = carIndex + 4'd1;
        end
      end
      default: begin
        stateNext = BCAST;
        idxNext   = '0;
      end
    endcase
  end

  // View of the slot about to be presented, including a spawn landing this cycle
  always_comb begin
    spawnHit   = spawnAccept && (freeIdx == idxNext);
    baseX      = slotX[idxNext];
    baseY      = slotY[idxNext];
    baseOrient = slotOrient[idxNext];
    baseActive = slotActive[idxNext];
    if (spawnHit) begin
      baseX      = spawn_x;
      baseY      = spawn_y;
      baseOrient = spawn_orient;
      baseActive = 1'b1;
    end
    moveEn = (stateNext == UPDATE) && baseActive;
  end

  car_step #(
    .STEP     (STEP),
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) stepUnit (
    .x      (baseX),
    .y      (baseY),
    .orient (baseOrient),
    .xNext  (stepX),
    .yNext  (stepY)
  );

  // Slot table: spawns write the free slot, the movement pass rewrites the swept slot
  always_ff @(posedge clk) begin
    if (rst) begin
      slotActive <= '0;
    end else begin
      if (spawnAccept) begin
        slotX[freeIdx]      <= spawn_x;
        slotY[freeIdx]      <= spawn_y;
        slotOrient[freeIdx] <= spawn_orient;
        slotActive[freeIdx] <= 1'b1;
      end
      if (moveEn) begin
        slotX[idxNext] <= stepX;
        slotY[idxNext] <= stepY;
      end
    end
  end

  // FSM state and registered broadcast outputs for the slot being presented
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BCAST;
      carIndex  <= '0;
      carX      <= INACTIVE_COORD;
      carY      <= INACTIVE_COORD;
      carOrient <= '0;
      carValid  <= 1'b0;
    end else begin
      state     <= stateNext;
      carIndex  <= idxNext;
      carValid  <= baseActive;
      carX      <= baseActive ? (moveEn ? stepX : baseX) : INACTIVE_COORD;
      carY      <= baseActive ? (moveEn ? stepY : baseY) : INACTIVE_COORD;
      carOrient <= baseActive ? baseOrient : 2'd0;
    end
  end

`ifdef CAR_BROADCASTER_OVERRUN_EN
  // Remember any tick that arrived while a movement pass was already running
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_overrun <= 1'b0;
    end else if (tick && (state == UPDATE)) begin
      tick_overrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_car_broadcaster.sv
// Directed bench for car_broadcaster: broadcast sweep, movement with wrap,
// full table back-pressure, dropped ticks and reset during a pass.
module tb_car_broadcaster;

  localparam logic [9:0] INACT = 10'd1023;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       spawn_valid = 1'b0;
  logic       spawn_ready;
  logic [9:0] spawn_x = '0;
  logic [9:0] spawn_y = '0;
  logic [1:0] spawn_orient = '0;
  logic [9:0] carX;
  logic [9:0] carY;
  logic [1:0] carOrient;
  logic [3:0] carIndex;
  logic       carValid;
`ifdef CAR_BROADCASTER_OVERRUN_EN
  logic       tick_overrun;
`endif

  int assertCount = 0;
  int failCount   = 0;

  logic [9:0] spX [12] = '{10'd0, 10'd10, 10'd20, 10'd30, 10'd40, 10'd50,
                           10'd60, 10'd70, 10'd80, 10'd90, 10'd100, 10'd110};
  logic [9:0] spY [12] = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5,
                           10'd6, 10'd7, 10'd8, 10'd9, 10'd10, 10'd11};
  logic [1:0] spO [12] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1,
                           2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [9:0] mvX [12] = '{10'd2, 10'd10, 10'd18, 10'd30, 10'd42, 10'd50,
                           10'd58, 10'd70, 10'd82, 10'd90, 10'd98, 10'd110};
  logic [9:0] mvY [12] = '{10'd0, 10'd3, 10'd2, 10'd1, 10'd4, 10'd7,
                           10'd6, 10'd5, 10'd8, 10'd11, 10'd10, 10'd9};

  car_broadcaster dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .spawn_valid  (spawn_valid),
    .spawn_ready  (spawn_ready),
    .spawn_x      (spawn_x),
    .spawn_y      (spawn_y),
    .spawn_orient (spawn_orient),
    .carX         (carX),
    .carY         (carY),
    .carOrient    (carOrient),
    .carIndex     (carIndex),
    .carValid     (carValid)
`ifdef CAR_BROADCASTER_OVERRUN_EN
    ,
    .tick_overrun (tick_overrun)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Drive inputs for the coming edge, then settle just past it
  task automatic applyStimulus(input logic r, input logic t, input logic v,
                               input logic [9:0] sx, input logic [9:0] sy,
                               input logic [1:0] so);
    rst          = r;
    tick         = t;
    spawn_valid  = v;
    spawn_x      = sx;
    spawn_y      = sy;
    spawn_orient = so;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 2'd0);
  endtask

  // Compare every broadcast output against the hand-derived expectation
  task automatic checkOutput(input string tag, input logic [3:0] eIdx,
                             input logic [9:0] eX, input logic [9:0] eY,
                             input logic [1:0] eO, input logic eV);
    assertCount++;
    assert (carIndex === eIdx) else begin
      failCount++;
      $error("[TB] FAIL %s carIndex: observed %0d expected %0d", tag, carIndex, eIdx);
    end
    assertCount++;
    assert (carX === eX) else begin
      failCount++;
      $error("[TB] FAIL %s carX: observed %0d expected %0d", tag, carX, eX);
    end
    assertCount++;
    assert (carY === eY) else begin
      failCount++;
      $error("[TB] FAIL %s carY: observed %0d expected %0d", tag, carY, eY);
    end
    assertCount++;
    assert (carOrient === eO) else begin
      failCount++;
      $error("[TB] FAIL %s carOrient: observed %0d expected %0d", tag, carOrient, eO);
    end
    assertCount++;
    assert (carValid === eV) else begin
      failCount++;
      $error("[TB] FAIL %s carValid: observed %0d expected %0d", tag, carValid, eV);
    end
  endtask

  task automatic checkReady(input string tag, input logic eR);
    assertCount++;
    assert (spawn_ready === eR) else begin
      failCount++;
      $error("[TB] FAIL %s spawn_ready: observed %0d expected %0d", tag, spawn_ready, eR);
    end
  endtask

`ifdef CAR_BROADCASTER_OVERRUN_EN
  task automatic checkOverrun(input string tag, input logic eO);
    assertCount++;
    assert (tick_overrun === eO) else begin
      failCount++;
      $error("[TB] FAIL %s tick_overrun: observed %0d expected %0d", tag, tick_overrun, eO);
    end
  endtask
`endif

  initial begin
    // Reset state, then two full idle sweeps
    applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 2'd0);
    checkOutput("reset", 4'd0, INACT, INACT, 2'd0, 1'b0);
    checkReady("resetReady", 1'b0);
`ifdef CAR_BROADCASTER_OVERRUN_EN
    checkOverrun("resetOverrun", 1'b0);
`endif
    rst = 1'b0;
    #1;
    checkReady("readyAfterReset", 1'b1);
    for (int i = 0; i < 24; i++) begin
      checkOutput($sformatf("idle%0d", i), 4'(i % 12), INACT, INACT, 2'd0, 1'b0);
      idle();
    end

    // Single car moving +x
    applyStimulus(1'b0, 1'b0, 1'b1, 10'd100, 10'd200, 2'd0);
    checkOutput("afterSpawn", 4'd1, INACT, INACT, 2'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 2'd0);
    checkOutput("upd0", 4'd0, 10'd102, 10'd200, 2'd0, 1'b1);
    checkReady("readyInUpdate", 1'b0);
    for (int c = 1; c < 12; c++) begin
      idle();
      checkOutput($sformatf("updEmpty%0d", c), 4'(c), INACT, INACT, 2'd0, 1'b0);
    end
    idle();
    checkOutput("bcastAfterPass", 4'd0, 10'd102, 10'd200, 2'd0, 1'b1);
    checkReady("readyAfterPass", 1'b1);

    // Edge wrap cases; third spawn lands in the same cycle as the tick
    applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 2'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 10'd639, 10'd10, 2'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 10'd1, 10'd479, 2'd3);
    applyStimulus(1'b0, 1'b1, 1'b1, 10'd0, 10'd5, 2'd2);
    checkOutput("wrapPosX", 4'd0, 10'd1, 10'd10, 2'd0, 1'b1);
    idle();
    checkOutput("wrapNegY", 4'd1, 10'd1, 10'd477, 2'd3, 1'b1);
    idle();
    checkOutput("wrapNegX", 4'd2, 10'd638, 10'd5, 2'd2, 1'b1);
    for (int c = 0; c < 10; c++) idle();
    checkOutput("wrapBcast", 4'd0, 10'd1, 10'd10, 2'd0, 1'b1);

    // Fill all twelve slots, then hold a thirteenth request
    applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 2'd0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, spX[i], spY[i], spO[i]);
    end
    checkReady("readyFull", 1'b0);
    for (int i = 0; i < 12; i++) begin
      checkOutput($sformatf("full%0d", i), 4'(i), spX[i], spY[i], spO[i], 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 10'd5, 10'd5, 2'd1);
    end

    // Movement pass with an extra tick at cycle 5 that must be dropped
    applyStimulus(1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 2'd0);
    for (int c = 0; c < 12; c++) begin
      checkOutput($sformatf("move%0d", c), 4'(c), mvX[c], mvY[c], spO[c], 1'b1);
      applyStimulus(1'b0, (c == 5) ? 1'b1 : 1'b0, 1'b0, 10'd0, 10'd0, 2'd0);
    end
    checkOutput("noSecondPass0", 4'd0, mvX[0], mvY[0], spO[0], 1'b1);
`ifdef CAR_BROADCASTER_OVERRUN_EN
    checkOverrun("overrunSet", 1'b1);
`endif
    idle();
    checkOutput("noSecondPass1", 4'd1, mvX[1], mvY[1], spO[1], 1'b1);

    // Reset in the middle of a second pass
    applyStimulus(1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 2'd0);
    checkOutput("secondMove0", 4'd0, 10'd4, 10'd0, 2'd0, 1'b1);
    for (int c = 1; c <= 6; c++) idle();
    checkOutput("secondMove6", 4'd6, 10'd56, 10'd6, 2'd2, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 2'd0);
    checkOutput("midReset", 4'd0, INACT, INACT, 2'd0, 1'b0);
    checkReady("midResetReady", 1'b0);
`ifdef CAR_BROADCASTER_OVERRUN_EN
    checkOverrun("overrunCleared", 1'b0);
`endif
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      checkOutput($sformatf("cleared%0d", i), 4'(i), INACT, INACT, 2'd0, 1'b0);
      idle();
    end

    // Spawn into slot 0 on the same edge the pass starts on slot 0
    applyStimulus(1'b0, 1'b1, 1'b1, 10'd5, 10'd5, 2'd1);
    checkOutput("spawnTickSame", 4'd0, 10'd5, 10'd7, 2'd1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/car_broadcaster.md
CAR_BROADCASTER -- requirements
Module: car_broadcaster

Interface
REQ-001 Parameter NUM_CARS, default 12, number of car slots.
REQ-002 Parameter STEP, default 2, pixels moved per tick.
REQ-003 Parameter SCREEN_W, default 640; SCREEN_H, default 480, wrap bounds in pixels.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 tick  in  1  one-cycle pulse requesting a movement update.
REQ-007 spawn_valid  in  1  new-car request.
REQ-008 spawn_ready  out  1  free slot available and FSM in BCAST.
REQ-009 spawn_x / spawn_y  in  10 / 10  spawn position.
REQ-010 spawn_orient  in  2  direction: 0 = +x, 1 = +y, 2 = -x, 3 = -y.
REQ-011 carX / carY  out  10 / 10  position of slot carIndex.
REQ-012 carOrient  out  2  orientation of slot carIndex.
REQ-013 carIndex  out  4  slot currently presented.
REQ-014 carValid  out  1  presented slot is active.

Function
REQ-015 Per-slot state SHALL be x[9:0], y[9:0], orient[1:0] and active.
REQ-016 FSM SHALL have exactly two states, BCAST and UPDATE.
REQ-017 In BCAST, carIndex SHALL step 0..NUM_CARS-1 one per cycle, then wrap to 0.
REQ-018 Outputs SHALL be registered; carX/carY/carOrient/carValid SHALL reflect slot carIndex as of the same cycle, with 1-cycle latency from the slot write.
REQ-019 Inactive slots SHALL present carX = carY = 1023, carOrient = 0 and carValid = 0.
REQ-020 A tick in BCAST SHALL move the FSM to UPDATE on the next cycle with the index reset to 0.
REQ-021 In UPDATE, the FSM SHALL process one slot per cycle for NUM_CARS cycles.
- Active slots move STEP along orient.
- The output presents the post-move value of the slot being updated.
- The FSM returns to BCAST after slot NUM_CARS-1, with the index wrapping to 0.
REQ-022 Wrap-around rules:
- +x: x+STEP >= SCREEN_W gives x+STEP-SCREEN_W.
- -x: x < STEP gives x+SCREEN_W-STEP.
- y follows the same rules using SCREEN_H.
- All arithmetic is 11-bit internally, truncated to 10 bits.
REQ-023 A tick arriving while in UPDATE SHALL be dropped.
REQ-024 spawn_ready SHALL be high only in BCAST when at least one slot is inactive.
REQ-025 On spawn_valid && spawn_ready, the lowest-index inactive slot SHALL be written and set active in that cycle.
REQ-026 Spawn and tick in the same cycle SHALL both be accepted; the spawned car SHALL be moved by the resulting UPDATE pass.
REQ-027 spawn_ready SHALL be low in UPDATE; spawn_valid SHALL be held by the source until accepted.

Reset
REQ-028 Reset SHALL clear all active bits, enter BCAST and set carIndex = 0.
REQ-029 Reset SHALL set carX = carY = 1023, carOrient = 0, carValid = 0 and spawn_ready = 0 in the reset cycle.
REQ-030 Reset asserted mid-UPDATE SHALL abort the pass; no slot state survives.

Configuration
REQ-031 Macro CAR_BROADCASTER_OVERRUN_EN SHALL control the overrun flag:
- Defined: adds output tick_overrun (1 bit), sticky, set by a tick during UPDATE, cleared only by rst.
- Undefined: the port is absent and dropped ticks are silent.

Structure
REQ-032 Shared package car_pkg SHALL hold:
- NUM_CARS, STEP, SCREEN_W, SCREEN_H;
- orientation encodings;
- the FSM state enum;
- the inactive-slot coordinate value 1023.
REQ-033 Next-position computation with wrap SHALL be the combinational sub-module car_step.

Verification
REQ-034 Reset, then 24 idle cycles -> carIndex 0..11 twice, carValid = 0 throughout, spawn_ready = 1 after reset.
REQ-035 Spawn (100, 200, orient 0), then tick -> slot 0 presents x = 102, y = 200 in UPDATE cycle 0.
REQ-036 Spawn (639, 10, 0) and (1, 479, 3), then tick -> (1, 10) and (1, 477); a further spawn (0, 5, 2) and tick -> (638, 5).
REQ-037 Spawn 12 cars -> spawn_ready = 0; a 13th spawn_valid stays pending with no slot written.
REQ-038 Tick at UPDATE cycle 5 -> pass completes normally with no second pass; tick_overrun = 1 if the macro is defined.
REQ-039 rst at UPDATE cycle 6 -> next cycle in BCAST, all carValid = 0, carIndex = 0.
